// File: rtl/scroll_pkg.sv
// scroll_pkg: character codes, FSM states and default message for char_scroller.
package scroll_pkg;
  typedef enum logic [2:0] {
    CH_D     = 3'd0,
    CH_E     = 3'd1,
    CH_ONE   = 3'd2,
    CH_ZERO  = 3'd3,
    CH_TWO   = 3'd4,
    CH_BLANK = 3'd7
  } char_e;

  typedef enum logic [1:0] {
    ST_PAUSE,
    ST_RUN,
    ST_LOAD
  } state_e;

  localparam int NUM_DISP = 8;

  // Position 0 is the rightmost (lowest) element: "two", "E", "d", then blanks.
  localparam logic [3*NUM_DISP-1:0] DEFAULT_MSG = {
    CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_D, CH_E, CH_TWO
  };

  function automatic logic [2:0] default_char(int i);
    return (i < NUM_DISP) ? DEFAULT_MSG[3*i +: 3] : CH_BLANK;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler that pulses tick on its last count while run is high.
module tick_gen #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] TOP = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic at_top;

  assign at_top = cnt_q == TOP;
  assign tick   = run & at_top;

  always_comb cnt_d = clr ? '0 : !run ? cnt_q : at_top ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/char_scroller.sv
// char_scroller: rotates a row of 3-bit character codes left/right on a timed tick
// or a manual step, with a message-load handshake.
module char_scroller
  import scroll_pkg::*;
#(
  parameter int NUM_DISP    = scroll_pkg::NUM_DISP,
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  step,
  input  logic                  ld_valid,
  input  logic [3*NUM_DISP-1:0] ld_data,
  output logic                  ld_ready,
  output logic [3*NUM_DISP-1:0] char_vec,
  output logic [2:0]            pos,
  output logic                  wrap
);
  localparam int W = 3 * NUM_DISP;
  localparam logic [2:0] LAST = 3'(NUM_DISP - 1);

  function automatic logic [W-1:0] build_default();
    logic [W-1:0] v;
    for (int i = 0; i < NUM_DISP; i++) v[3*i +: 3] = default_char(i);
    return v;
  endfunction

  localparam logic [W-1:0] DEF_MSG = build_default();

  state_e state_q, state_d;
  logic [W-1:0] chars_q, chars_d;
  logic [2:0] pos_q, pos_d;
  logic wrap_q, wrap_d;
  logic accept, tick, adv, at_edge;

  assign ld_ready = state_q != ST_LOAD;
  assign accept   = ld_valid & ld_ready;
  // A load wins over any tick or step landing on the same edge.
  assign adv      = !accept & (tick | (state_q == ST_PAUSE & step));
  assign at_edge  = dir ? pos_q == 3'd0 : pos_q == LAST;
  assign state_d  = accept ? ST_LOAD : en ? ST_RUN : ST_PAUSE;

  always_comb begin
    chars_d = accept ? ld_data : !adv ? chars_q :
              dir ? {chars_q[2:0], chars_q[W-1:3]} : {chars_q[W-4:0], chars_q[W-1 -: 3]};
    pos_d   = accept ? 3'd0 : !adv ? pos_q :
              dir ? (at_edge ? LAST : pos_q - 3'd1) : (at_edge ? 3'd0 : pos_q + 3'd1);
    wrap_d  = adv & at_edge;
  end

  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (state_q == ST_RUN),
    .clr  (accept),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_PAUSE;
      chars_q <= DEF_MSG;
      pos_q   <= 3'd0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chars_q <= chars_d;
      pos_q   <= pos_d;
      wrap_q  <= wrap_d;
    end

  assign char_vec = chars_q;
  assign pos      = pos_q;
  assign wrap     = wrap_q;
endmodule

// File: doc/char_scroller.md
CHAR_SCROLLER -- requirements
Module: char_scroller

Interface
REQ-001 Parameter NUM_DISP, default 8, number of seven-segment character positions.
REQ-002 Parameter TICK_CYCLES, default 50_000_000, clk cycles per scroll step (1 s at 50 MHz); legal range 2 and up.
REQ-003 Reset and clock are fixed: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  level; 1 = auto-scroll, 0 = paused.
REQ-007 dir  input  1  0 = scroll left (toward hex_disp[NUM_DISP-1]), 1 = scroll right.
REQ-008 step  input  1  single-cycle pulse; advances one position while paused.
REQ-009 ld_valid  input  1  new message offered.
REQ-010 ld_data  input  NUM_DISPx3  new message; element i is the code for position i.
REQ-011 ld_ready  output  1  message load accepted when ld_valid and ld_ready are both high at a clk edge.
REQ-012 char_vec  output  NUM_DISPx3  registered character codes, one per position, feeding the 3-bit character decoders.
REQ-013 pos  output  3  net rotation count modulo NUM_DISP since the last load or reset.
REQ-014 wrap  output  1  one-cycle pulse when pos wraps.

Function
REQ-015 Character codes: 0 d, 1 E, 2 one, 3 zero, 4 two, 7 blank; 5 and 6 are passed through unmodified.
REQ-016 Prescaler counts 0..TICK_CYCLES-1 and wraps; it raises an internal tick for exactly one cycle when it is at TICK_CYCLES-1.
REQ-017 Prescaler runs only in RUN; in PAUSE it holds its value.
REQ-018 FSM states: PAUSE, RUN, LOAD.
REQ-019 Transitions: PAUSE->RUN when en=1; RUN->PAUSE when en=0; any state->LOAD on load accept; LOAD->RUN if en=1, else LOAD->PAUSE, after exactly one cycle.
REQ-020 Left step: new char_vec[i] = old char_vec[i-1 mod NUM_DISP]; pos increments; 7->0 pulses wrap.
REQ-021 Right step: new char_vec[i] = old char_vec[i+1 mod NUM_DISP]; pos decrements; 0->7 pulses wrap.
REQ-022 Step sources: tick in RUN; step pulse in PAUSE. In RUN, step is ignored; in PAUSE, tick never occurs.
REQ-023 Load accept writes ld_data into char_vec, clears pos and the prescaler, and suppresses any coincident tick or step.
REQ-024 ld_ready is 1 in PAUSE and RUN and 0 in LOAD, so back-to-back loads are at least two cycles apart.
REQ-025 A dir change takes effect on the next step; a step never uses a mixed direction.
REQ-026 Output latency: char_vec, pos and wrap update on the clk edge that performs the step or load.

Reset
REQ-027 Asserting rst_n low immediately forces the following, including mid-scroll and mid-load: state=PAUSE, prescaler=0, pos=0, wrap=0, ld_ready=1.
REQ-028 Asserting rst_n low also sets char_vec to the default message {7,7,7,7,7,0,1,4}, i.e. position 0=two, 1=E, 2=d, rest blank.
REQ-029 Leaving reset: the first tick occurs TICK_CYCLES cycles after RUN is entered.

Structure
REQ-030 Package scroll_pkg holds the char_e code enumeration, NUM_DISP default and DEFAULT_MSG constant.
REQ-031 Prescaler is a sub-module tick_gen (ports clk, rst_n, run, clr, tick); everything else stays in char_scroller.

Verification (TICK_CYCLES=4)
REQ-032 Reset, then en=1 for 8 ticks (32 cycles) -> char_vec advances left once every 4 cycles, returns to the default message, and pos 7->0 with wrap high for one cycle.
REQ-033 en=0, then step pulse with dir=1 -> default becomes pos[0]=E, pos[1]=d, pos[7]=two; pos=7; wrap=1 for one cycle; no further movement for 20 cycles.
REQ-034 ld_valid=1 in the cycle a tick is due, with ld_data all 3 -> char_vec all zero-code, pos=0, no rotation that cycle, ld_ready=0 next cycle, next tick 4 cycles after LOAD.
REQ-035 ld_valid held high for 3 cycles -> exactly two accepts, separated by a ld_ready=0 cycle.
REQ-036 rst_n low for 1 cycle mid-scroll at pos=5 -> all outputs immediately reset to REQ-027/REQ-028 values; scrolling resumes 4 cycles after RUN is re-entered.
REQ-037 en toggled 1->0 at prescaler=2, held 10 cycles, then 1 -> tick occurs 2 cycles after resume.
